// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the synchronous FIFO family.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Pointer width: one extra bit beyond the address so full and empty wraps differ.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows the read address combinationally.
// Backpressure: none; the controller only issues accepted writes.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; stale words are never exposed once pointers clear.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered status flags and optional first-word-fall-through.
// Latency: 1 cycle write-to-read-visible; FWFT=0 rdata one cycle after read, FWFT=1 head shown directly.
// Backpressure: writes dropped while full (overflow pulse), reads ignored while empty (underflow pulse).
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] L_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] L_AFULL  = CW'(AFULL_TH);
  localparam logic [CW-1:0] L_AEMPTY = CW'(AEMPTY_TH);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1) begin : g_chk_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 4");
  end
  if (AFULL_TH < 0 || AFULL_TH > DEPTH) begin : g_chk_afull
    $error("sync_fifo_param: AFULL_TH outside 0..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin : g_chk_aempty
    $error("sync_fifo_param: AEMPTY_TH outside 0..DEPTH");
  end

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full, r_empty, r_afull, r_aempty;
  logic             r_overflow, r_underflow;
  logic [WIDTH-1:0] r_rdata;

  logic             w_wr_acc, w_rd_acc, w_bypass;
  logic [PW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [AW-1:0]    w_raddr;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_wr_acc     = wr_en && !r_full;
  assign w_rd_acc     = rd_en && !r_empty;
  assign w_wr_ptr_nxt = r_wr_ptr + {{(PW-1){1'b0}}, w_wr_acc};
  assign w_rd_ptr_nxt = r_rd_ptr + {{(PW-1){1'b0}}, w_rd_acc};

  // In FWFT mode the word being written may itself become the next head; forward it.
  assign w_bypass = w_wr_acc && (w_rd_ptr_nxt == r_wr_ptr);
  // FWFT looks ahead to the post-edge head; registered mode reads the current head.
  assign w_raddr  = (FWFT != 0) ? w_rd_ptr_nxt[AW-1:0] : r_rd_ptr[AW-1:0];

  // Next occupancy: simultaneous accepted read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  // Pointers, count and flags; flags are computed from the next count so they never lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == L_DEPTH);
      r_empty     <= (w_count_nxt == '0);
      r_afull     <= (w_count_nxt >= L_AFULL);
      r_aempty    <= (w_count_nxt <= L_AEMPTY);
      r_overflow  <= wr_en && r_full;
      r_underflow <= rd_en && r_empty;
    end
  end

  // Output data register: tracks the head in FWFT mode, otherwise loads only on an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (FWFT != 0) begin
      r_rdata <= w_bypass ? wdata : w_ram_rdata;
    end else if (w_rd_acc) begin
      r_rdata <= w_ram_rdata;
    end
  end

  assign rdata        = r_rdata;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param in registered and FWFT read modes.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: exercised through overflow/underflow and simultaneous access vectors.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, rd_en;
  logic [7:0] wdata, rdata;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr_en, f_rd_en;
  logic [7:0] f_wdata, f_rdata;
  logic       f_full, f_empty, f_afull, f_aempty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int n_asrt = 0;
  int n_fail = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .count(count)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wdata(f_wdata), .rd_en(f_rd_en), .rdata(f_rdata),
    .full(f_full), .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
    .overflow(f_overflow), .underflow(f_underflow), .count(f_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scoreboarded cycle on the registered-read instance.
  task automatic op(input logic wr, input logic rd, input logic [7:0] d);
    int         sz;
    logic       wa, ra;
    logic [7:0] exp_d;
    sz    = q.size();
    wa    = wr && (sz < 16);
    ra    = rd && (sz > 0);
    exp_d = ra ? q[0] : 8'h00;
    wr_en = wr; rd_en = rd; wdata = d;
    tick();
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    chk("sb_count", 32'(count), 32'(q.size()));
    chk("sb_empty", 32'(empty), 32'(q.size() == 0));
    chk("sb_full", 32'(full), 32'(q.size() == 16));
    chk("sb_overflow", 32'(overflow), 32'(wr && sz == 16));
    chk("sb_underflow", 32'(underflow), 32'(rd && sz == 0));
    if (ra) chk("sb_rdata", 32'(rdata), 32'(exp_d));
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wdata = 8'h00;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill 0x01..0x10: first write lands on the first edge after reset release.
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wdata = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 14));
      chk("fill_full", 32'(full), 32'(i == 16));
      chk("fill_aempty", 32'(almost_empty), 32'(i <= 2));
      chk("fill_empty", 32'(empty), 32'd0);
    end

    // Write while full: rejected, overflow for exactly one cycle.
    wr_en = 1'b1; wdata = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    tick();
    chk("ovf_clear", 32'(overflow), 32'd0);
    chk("ovf_count2", 32'(count), 32'd16);

    // Drain: each word one cycle after its read, no 0xAA.
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_rdata", 32'(rdata), 32'(i));
      chk("drain_count", 32'(count), 32'(16 - i));
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    tick();
    chk("drain_hold", 32'(rdata), 32'h10);

    // Read while empty: underflow for one cycle, rdata holds.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    tick();
    chk("unf_clear", 32'(underflow), 32'd0);
    chk("unf_hold", 32'(rdata), 32'h10);

    // Empty with write+read: write wins, read flagged.
    op(1'b1, 1'b1, 8'h55);
    chk("sim_empty_count", 32'(count), 32'd1);
    for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 8'(8'h60 + i));
    chk("at5_count", 32'(count), 32'd5);
    for (int i = 0; i < 10; i++) op(1'b1, 1'b1, 8'(8'h70 + i));
    chk("sim5_count", 32'(count), 32'd5);

    // Mixed traffic across pointer wrap.
    for (int i = 0; i < 40; i++) op((i % 3) != 2, (i % 2) == 1, 8'(8'h80 + i));
    for (int i = 0; i < 32 && q.size() != 7; i++) begin
      if (q.size() < 7) op(1'b1, 1'b0, 8'(8'hC0 + i));
      else op(1'b0, 1'b1, 8'h00);
    end
    chk("pre_rst_count", 32'(count), 32'd7);

    // Asynchronous reset mid-operation: outputs clear with no clock edge.
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_rdata", 32'(rdata), 32'd0);
    chk("arst_aempty", 32'(almost_empty), 32'd1);
    #1 rst = 1'b0;
    q.delete();
    op(1'b1, 1'b0, 8'h99);
    op(1'b0, 1'b1, 8'h00);

    // FWFT: head visible as soon as empty falls, advances on accepted read.
    f_wr_en = 1'b1; f_wdata = 8'h33;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_empty", 32'(f_empty), 32'd0);
    chk("fwft_first", 32'(f_rdata), 32'h33);
    f_wr_en = 1'b1; f_wdata = 8'h44;
    tick();
    f_wr_en = 1'b0;
    chk("fwft_hold", 32'(f_rdata), 32'h33);
    chk("fwft_count2", 32'(f_count), 32'd2);
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    chk("fwft_adv", 32'(f_rdata), 32'h44);
    f_wr_en = 1'b1; f_rd_en = 1'b1; f_wdata = 8'h45;
    tick();
    f_wr_en = 1'b0; f_rd_en = 1'b0;
    chk("fwft_bypass", 32'(f_rdata), 32'h45);
    chk("fwft_count1", 32'(f_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
